// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: WIDTH-bit adder evaluated CHUNK bits per clock with a
// registered ripple carry between chunks. Start/busy/done handshake; s, cout
// and ovf hold their values from the done cycle until the next accepted start.
// Optional build macro: ADDER_SUB_EN adds a `sub` input for a - b operation.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start, previous result held
// S_RUN  | adding one CHUNK-bit slice per clock, low slice first
// S_DONE | one cycle, done pulse high, start accepted back-to-back
`timescale 1ns/1ps

module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [WIDTH-1:0] b_eff;
    logic             c_init;
    logic [CHUNK:0]   chunk_sum;
    logic             ovf_next;

    // Operand conditioning at the start boundary: subtract is a + ~b + 1.
    always_comb begin
        b_eff  = b;
        c_init = cin;
`ifdef ADDER_SUB_EN
        if (sub) begin
            b_eff  = ~b;
            c_init = 1'b1;
        end
`endif
    end

    // One CHUNK-bit slice of the ripple add; the top slice also yields overflow.
    always_comb begin
        chunk_sum = {1'b0, op_a[int'(idx)*CHUNK +: CHUNK]}
                  + {1'b0, op_b[int'(idx)*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        // Only meaningful on the last slice, where bit CHUNK-1 is s[WIDTH-1].
        ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                   (chunk_sum[CHUNK-1] != op_a[WIDTH-1]);
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_eff;
                        carry <= c_init;
                        idx   <= '0;
                        s     <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    s[int'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry <= chunk_sum[CHUNK];
                    if (idx == LAST_IDX) begin
                        cout  <= chunk_sum[CHUNK];
                        ovf   <= ovf_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
